muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execution unit; sequential companion to the single-cycle ALU on the same operand/result path.
//  Takes op_1/op_2 plus func_3 from an instruction with func_7 = 7'b0000001.
//  Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle.
//  The core stalls on ready/done.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 is supported and verified
// PORTS
//  clk        in   1     core clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  start      in   1     request; sampled only when ready=1
//  flush      in   1     synchronous abort of an in-flight op, no done
//  func_3     in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op_1       in   XLEN  rs1 value (multiplicand / dividend)
//  op_2       in   XLEN  rs2 value (multiplier / divisor)
//  ready      out  1     1 only in IDLE; the unit can accept start
//  busy       out  1     1 in CALC or DONE
//  done       out  1     one-cycle pulse; result is valid this cycle
//  result     out  XLEN  last completed result; held until the next done
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on start=1 at an edge, latch func_3/op_1/op_2.
//    Signed ops take operand magnitudes and record the result sign.
//    Signedness: MULH, DIV, REM = both operands signed; MULHSU = op_1 signed, op_2 unsigned; others unsigned.
//    Go to CALC with count=0.
//   CALC: one iteration per cycle for exactly 32 cycles (count 0..31).
//    Multiply: shift-add into a 64-bit accumulator.
//    Divide: restoring, 1 quotient bit per cycle, 33-bit partial remainder.
//    After count=31, go to DONE.
//   DONE: apply sign fix, write result, done=1 for this cycle only, go to IDLE.
//  Latency is fixed at 34 cycles for all ops and data values (no early-out).
//   start sampled at edge N -> done=1 in the cycle after edge N+33.
//   The earliest next start is sampled at edge N+34.
//  Result selection:
//   MUL = low 32 bits of the product.
//   MULH/MULHSU/MULHU = high 32 bits of the 64-bit signed/mixed/unsigned product.
//   DIV/DIVU = quotient, truncated toward zero.
//   REM/REMU = remainder; its sign follows the dividend.
//  Special cases are produced in DONE with the same latency:
//   divisor=0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> op_1.
//   DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM of the same operands -> 0.
//  start while ready=0 is ignored (not queued); operands may change freely after acceptance.
//  flush=1 in CALC or DONE: next state IDLE, done stays 0, result keeps its old value.
//   flush has priority over DONE completion. flush in IDLE does nothing.
//  start and flush both 1 in IDLE: flush wins and start is ignored.
//  Reset asserted mid-operation: immediate return to reset values; no done pulse.
//  done never asserts without a preceding accepted start.
//  result changes only on the done cycle.
// TESTING
//  MUL 7 x 32'hFFFF_FFFD -> result 32'hFFFF_FFEB, done exactly 34 cycles after start.
//  MULH 32'h8000_0000 x 32'h8000_0000 -> 32'h4000_0000.
//   MULHSU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
//   MULHU same operands -> 32'hFFFF_FFFE.
//  DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  Divide by 0 with op_1=32'h1234: DIV -> 32'hFFFF_FFFF, REM -> 32'h1234.
//   DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM of the same -> 0.
//  start re-pulsed at cycle 10 of a busy op is ignored (one done only).
//   flush at cycle 20 -> no done, result unchanged, ready=1 next cycle.
//  rst_n low at cycle 15 of a DIV -> ready=1, result=0 immediately; a following MUL 3x5 -> 15 with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// fixed 34-cycle latency from accepted start to the done pulse, with flush and async reset.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [2:0]        func_q;
  logic [XLEN-1:0]   a_q, b_q, rem_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q, neg_a_q, done_q;

  logic              signed_a, signed_b, neg_1, neg_2;
  logic [XLEN-1:0]   mag_1, mag_2;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_fit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_d;

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    signed_a = func_3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    signed_b = func_3 inside {3'b001, 3'b100, 3'b110};
    neg_1    = signed_a & op_1[XLEN-1];
    neg_2    = signed_b & op_2[XLEN-1];
    mag_1    = neg_1 ? -op_1 : op_1;
    mag_2    = neg_2 ? -op_2 : op_2;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_fit   = div_shift >= {1'b0, b_q};

    // Divide-by-zero quotient is all ones regardless of sign; the remainder
    // naturally equals the dividend, and signed overflow falls out of the magnitudes.
    prod = neg_q ? -acc_q : acc_q;
    quo  = (b_q == '0) ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem  = neg_a_q ? -rem_q : rem_q;

    case (func_q)
      3'b000:                 res_d = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_d = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_d = quo;
      default:                res_d = rem;
    endcase
  end

  // NOTE: the whole datapath is reset, not just the control, so no stale operand survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            func_q  <= func_3;
            a_q     <= mag_1;
            b_q     <= mag_2;
            neg_q   <= neg_1 ^ neg_2;
            neg_a_q <= neg_1;
            rem_q   <= '0;
            acc_q   <= {{XLEN{1'b0}}, func_3[2] ? mag_1 : mag_2};
            count_q <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            if (func_q[2]) begin
              rem_q <= div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
              acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_fit};
            end else begin
              acc_q <= {mul_sum, acc_q[XLEN-1:1]};
            end
            count_q <= count_q + 1'b1;
            if (count_q == LAST) state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (!flush) begin
            result_q <= res_d;
            done_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control corner cases and
// random operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func_3 = '0;
  logic [31:0] op_1 = '0;
  logic [31:0] op_2 = '0;
  logic        ready, busy, done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .func_3(func_3),
    .op_1(op_1), .op_2(op_2), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, ps;
    longint unsigned pu;
    int              ia, ib;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pu  = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return pu[31:0];
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * ub; return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          cyc;
    exp = model(f, a, b);
    @(negedge clk);
    func_3 = f; op_1 = a; op_2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_1 = $urandom; op_2 = $urandom; func_3 = 3'($urandom);
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 32'd34);
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " pulse/ready"}, {30'b0, done, ready}, 32'b01);
    last_res = exp;
  endtask

  initial begin
    int dones;
    logic [31:0] seen;

    #12;
    check("reset outputs", {28'b0, ready, busy, done, 1'b0}, {28'b0, 4'b1000});
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd4, -32'sd7, 32'd2, "div neg");
    run_op(3'd6, -32'sd7, 32'd2, "rem neg");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd4, 32'h1234, 32'h0, "div by0");
    run_op(3'd6, 32'h1234, 32'h0, "rem by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    func_3 = 3'd5; op_1 = 32'd1000; op_2 = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    func_3 = 3'd0; op_1 = 32'd5; op_2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    seen = 32'hDEAD_BEEF;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        seen = result;
      end
    end
    check("repulse done count", dones, 32'd1);
    check("repulse result", seen, 32'd100);
    last_res = 32'd100;

    // Flush mid-calculation: no done, result held.
    @(negedge clk);
    func_3 = 3'd0; op_1 = 32'd11; op_2 = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush ready", {30'b0, ready, busy}, 32'b10);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush no done", dones, 32'd0);
    check("flush result held", result, last_res);

    // start together with flush in idle: flush wins.
    @(negedge clk);
    func_3 = 3'd0; op_1 = 32'd2; op_2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush idle", {30'b0, ready, busy}, 32'b10);

    // Reset in the middle of a divide.
    @(negedge clk);
    func_3 = 3'd4; op_1 = 32'h1234_5678; op_2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset state", {29'b0, ready, busy, done}, 32'b100);
    check("midreset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, "mul after reset");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, $sformatf("rand%0d f%0d", i, f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
